// File: rtl/dmem_responder.sv
// Handshaked load/store data-memory responder with programmable access latency.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned H/W accesses fault).
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [2:0]    ctrl_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          illegal;
  logic          misalign;
  logic          fault;
  logic          commit;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [31:0]   rdata_d;
  logic          err_d;

  // Address bits above the array index are deliberately discarded (wrap-around).
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  assign idx    = addr_q[AW+1:2];
  assign word   = mem_q[idx];
  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

  always_comb begin
    byte_sel = word[7:0];
    case (addr_q[1:0])
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  assign half_sel = addr_q[1] ? word[31:16] : word[15:0];

  // Stores allow only B/H/W; loads additionally allow BU/HU.
  assign illegal = we_q ? (ctrl_q[2] || (ctrl_q[1:0] == 2'b11))
                        : ((ctrl_q[1:0] == 2'b11) || (ctrl_q == 3'b110));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((ctrl_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((ctrl_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault = illegal || misalign;
  assign err_d = fault;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    be      = 4'b0000;
    wlanes  = 32'd0;
    rdata_d = 32'd0;
    if (!fault) begin
      if (we_q) begin
        case (ctrl_q[1:0])
          2'b00: begin
            be     = 4'b0001 << addr_q[1:0];
            wlanes = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            be     = addr_q[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{wdata_q[15:0]}};
          end
          default: begin
            be     = 4'b1111;
            wlanes = wdata_q;
          end
        endcase
      end else begin
        case (ctrl_q[1:0])
          2'b00:   rdata_d = ctrl_q[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
          2'b01:   rdata_d = ctrl_q[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
          default: rdata_d = word;
        endcase
      end
    end
  end

  // NOTE: the array has no reset; its contents are undefined after power-up by design.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      ctrl_q      <= 3'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr[AW+1:0];
            wdata_q     <= req_wdata;
            we_q        <= req_we;
            ctrl_q      <= req_ctrl;
            cnt_q       <= 4'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          // Re-opening the request channel is deferred to the cycle after the handshake.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=4, DEPTH_WORDS=1024).
module tb_dmem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  localparam logic [2:0] C_B = 3'b000, C_H = 3'b001, C_W = 3'b010,
                         C_BU = 3'b100, C_HU = 3'b101;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_we    (req_we),
    .req_ctrl  (req_ctrl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction; returns the response and cycles from acceptance to rsp_valid.
  task automatic access(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int cycles);
    @(negedge clk);
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cycles = 0;
    while (!rsp_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_we = 1'b0; req_ctrl = '0; rsp_ready = 1'b0;
    #23;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err",   32'(rsp_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Store/load word with latency measurement.
    access(1'b1, C_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("sw_rdata_zero", rd, 32'd0);
    check("sw_err",        32'(er), 32'd0);
    check("sw_latency",    32'(lat), 32'(LAT));
    access(1'b0, C_W, 32'h10, 32'h0, rd, er, lat);
    check("lw_rdata",   rd, 32'hDEADBEEF);
    check("lw_err",     32'(er), 32'd0);
    check("lw_latency", 32'(lat), 32'(LAT));

    // Backpressure: response holds, request channel closed and ignored.
    access(1'b1, C_W, 32'h30, 32'h0BADF00D, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_ctrl = C_W; req_addr = 32'h10;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
    for (int k = 0; k < 40 && !rsp_valid; k++) begin @(posedge clk); #1; end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("bp_release_req_ready", 32'(req_ready), 32'd1);
    check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    access(1'b0, C_W, 32'h30, 32'h0, rd, er, lat);
    check("bp_ignored_store", rd, 32'h0BADF00D);

    // Byte store and extension.
    access(1'b1, C_W, 32'h10, 32'h0, rd, er, lat);
    access(1'b1, C_B, 32'h13, 32'h00000080, rd, er, lat);
    access(1'b0, C_B, 32'h13, 32'h0, rd, er, lat);
    check("lb_sign",  rd, 32'hFFFFFF80);
    access(1'b0, C_BU, 32'h13, 32'h0, rd, er, lat);
    check("lbu_zero", rd, 32'h00000080);
    access(1'b0, C_W, 32'h10, 32'h0, rd, er, lat);
    check("lw_after_sb", rd, 32'h80000000);

    // Halfword store and extension.
    access(1'b1, C_W, 32'h50, 32'h0, rd, er, lat);
    access(1'b1, C_H, 32'h52, 32'h12348001, rd, er, lat);
    access(1'b0, C_W, 32'h50, 32'h0, rd, er, lat);
    check("lw_after_sh", rd, 32'h80010000);
    access(1'b0, C_H, 32'h52, 32'h0, rd, er, lat);
    check("lh_sign",  rd, 32'hFFFF8001);
    access(1'b0, C_HU, 32'h52, 32'h0, rd, er, lat);
    check("lhu_zero", rd, 32'h00008001);

    // Illegal ctrl codes.
    access(1'b1, C_BU, 32'h50, 32'hFFFFFFFF, rd, er, lat);
    check("st_illegal_err", 32'(er), 32'd1);
    access(1'b1, 3'b011, 32'h50, 32'hFFFFFFFF, rd, er, lat);
    check("st_011_err", 32'(er), 32'd1);
    access(1'b0, C_W, 32'h50, 32'h0, rd, er, lat);
    check("st_illegal_nowrite", rd, 32'h80010000);
    access(1'b0, 3'b110, 32'h50, 32'h0, rd, er, lat);
    check("ld_illegal_rdata", rd, 32'd0);
    check("ld_illegal_err",   32'(er), 32'd1);

    // Misaligned word store.
    access(1'b1, C_W, 32'h20, 32'h0, rd, er, lat);
    access(1'b1, C_W, 32'h22, 32'h12345678, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misalign_err", 32'(er), 32'd1);
    access(1'b0, C_W, 32'h20, 32'h0, rd, er, lat);
    check("misalign_nowrite", rd, 32'h0);
`else
    check("misalign_err", 32'(er), 32'd0);
    access(1'b0, C_W, 32'h20, 32'h0, rd, er, lat);
    check("misalign_aligned_write", rd, 32'h12345678);
`endif

    // Reset while a store is in BUSY.
    access(1'b1, C_W, 32'h40, 32'h11223344, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_ctrl = C_W; req_addr = 32'h40; req_wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_busy_rsp_err",   32'(rsp_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    access(1'b0, C_W, 32'h40, 32'h0, rd, er, lat);
    check("rst_busy_nowrite", rd, 32'h11223344);

    // Address wrap modulo DEPTH_WORDS*4.
    access(1'b1, C_W, 32'h4, 32'h0, rd, er, lat);
    access(1'b1, C_W, 32'h1004, 32'h00000001, rd, er, lat);
    access(1'b0, C_W, 32'h0004, 32'h0, rd, er, lat);
    check("addr_wrap", rd, 32'h00000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
